// File: rtl/fp_packer.sv
// -----------------------------------------------------------------------------
// fp_packer
//   Result packer for the FPU back end. Takes a rounded result (sign, biased
//   exponent, 53-bit significand with explicit hidden bit, class flags) and
//   packs it into an IEEE-754 double word, or a single word in fp[63:32].
//   Two-stage valid/ready pipeline:
//     S1 captures the inputs and decodes the result class.
//     S2 registers the packed word onto fp.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   upstream result valid
//   in_ready   out  1   packer can accept a result this cycle
//   db         in   1   1 = double, 0 = single
//   s          in   1   result sign
//   e          in  11   biased exponent (single uses e[7:0])
//   f          in  53   significand, f[52] = hidden bit (single uses f[52:29])
//   fl         in   4   flags {ZERO, INF, SNAN, NAN}
//   nan        in  53   {nan_sign, nan_frac[51:0]} from the NaN selector
//   out_valid  out  1   packed word valid
//   out_ready  in   1   downstream accepts
//   fp         out 64   packed result
//   nan_cnt    out 16   saturating count of emitted NaN words (macro only)
//   inf_cnt    out 16   saturating count of emitted INF words (macro only)
//
// Configuration
//   FP_PACKER_EXC_CNT_EN : when defined, adds the nan_cnt/inf_cnt outputs and
//   carries the result class into S2. Datapath behaviour is identical either way.
// -----------------------------------------------------------------------------
module fp_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        db,
   input  logic        s,
   input  logic [10:0] e,
   input  logic [52:0] f,
   input  logic [3:0]  fl,
   input  logic [52:0] nan,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] fp
`ifdef FP_PACKER_EXC_CNT_EN
   ,
   output logic [15:0] nan_cnt,
   output logic [15:0] inf_cnt
`endif
);

   typedef enum logic [1:0] {
      CLS_FIN  = 2'd0,
      CLS_ZERO = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } cls_e;

   // Class priority: any NaN flag beats INF, which beats ZERO.
   function automatic cls_e decode_class(input logic [3:0] flags);
      cls_e c;
      c = CLS_FIN;
      if (flags[1] || flags[0]) c = CLS_NAN;
      else if (flags[2])        c = CLS_INF;
      else if (flags[3])        c = CLS_ZERO;
      return c;
   endfunction

   function automatic logic [63:0] pack_word(input cls_e        cls,
                                             input logic        dbl,
                                             input logic        sgn,
                                             input logic [10:0] exp_in,
                                             input logic [52:0] sig,
                                             input logic [52:0] nanw);
      logic [63:0] w;
      logic [10:0] exp_fin;
      logic [51:0] qnan_d;
      logic [22:0] qnan_s;
      w       = 64'h0;
      // Denormal (hidden bit clear) forces a zero exponent field.
      exp_fin = sig[52] ? exp_in : 11'h000;
      // Quiet bit (frac MSB) is always set on a packed NaN.
      qnan_d  = nanw[51:0]  | 52'h8_0000_0000_0000;
      qnan_s  = nanw[51:29] | 23'h40_0000;
      unique case (cls)
         CLS_NAN:  w = dbl ? {nanw[52], 11'h7FF, qnan_d}
                           : {nanw[52], 8'hFF, qnan_s, 32'h0};
         CLS_INF:  w = dbl ? {sgn, 11'h7FF, 52'h0}
                           : {sgn, 8'hFF, 23'h0, 32'h0};
         CLS_ZERO: w = {sgn, 63'h0};
         default:  w = dbl ? {sgn, exp_fin, sig[51:0]}
                           : {sgn, exp_fin[7:0], sig[51:29], 32'h0};
      endcase
      return w;
   endfunction

`ifdef FP_PACKER_EXC_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
      return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   endfunction
`endif

   logic        vld_p1_q, vld_p1_d;
   logic        vld_p2_q, vld_p2_d;
   logic        db_p1_q;
   logic        s_p1_q;
   logic [10:0] e_p1_q;
   logic [52:0] f_p1_q;
   logic [52:0] nan_p1_q;
   cls_e        cls_p1_q;
   logic [63:0] fp_p2_q, fp_p2_d;
   logic        adv_p1, adv_p2, take_p1;

   assign adv_p2    = !vld_p2_q || out_ready;
   assign adv_p1    = adv_p2 || !vld_p1_q;
   assign take_p1   = in_valid && adv_p1;
   assign in_ready  = adv_p1;
   assign out_valid = vld_p2_q;
   assign fp        = fp_p2_q;

   always_comb begin
      vld_p1_d = vld_p1_q;
      vld_p2_d = vld_p2_q;
      fp_p2_d  = fp_p2_q;
      if (adv_p1) vld_p1_d = in_valid;
      if (adv_p2) vld_p2_d = vld_p1_q;
      // fp only changes when a new word moves in, so it holds under stall.
      if (adv_p2 && vld_p1_q)
         fp_p2_d = pack_word(cls_p1_q, db_p1_q, s_p1_q, e_p1_q, f_p1_q, nan_p1_q);
   end

   // ---- S1: capture and class decode ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_p1_q <= 1'b0;
      else        vld_p1_q <= vld_p1_d;
   end

   always_ff @(posedge clk) begin
      if (take_p1) begin
         db_p1_q  <= db;
         s_p1_q   <= s;
         e_p1_q   <= e;
         f_p1_q   <= f;
         nan_p1_q <= nan;
         cls_p1_q <= decode_class(fl);
      end
   end

   // ---- S2: packed word ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2_q <= 1'b0;
         fp_p2_q  <= 64'h0;
      end else begin
         vld_p2_q <= vld_p2_d;
         fp_p2_q  <= fp_p2_d;
      end
   end

`ifdef FP_PACKER_EXC_CNT_EN
   cls_e        cls_p2_q;
   logic [15:0] nan_cnt_q, nan_cnt_d;
   logic [15:0] inf_cnt_q, inf_cnt_d;

   always_comb begin
      nan_cnt_d = nan_cnt_q;
      inf_cnt_d = inf_cnt_q;
      if (vld_p2_q && out_ready) begin
         if (cls_p2_q == CLS_NAN) nan_cnt_d = sat_inc(nan_cnt_q);
         if (cls_p2_q == CLS_INF) inf_cnt_d = sat_inc(inf_cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (adv_p2 && vld_p1_q) cls_p2_q <= cls_p1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nan_cnt_q <= 16'h0;
         inf_cnt_q <= 16'h0;
      end else begin
         nan_cnt_q <= nan_cnt_d;
         inf_cnt_q <= inf_cnt_d;
      end
   end

   assign nan_cnt = nan_cnt_q;
   assign inf_cnt = inf_cnt_q;
`endif

endmodule

// File: tb/tb_fp_packer.sv
// -----------------------------------------------------------------------------
// tb_fp_packer
//   Self-checking bench for fp_packer. A queue-based reference model predicts
//   out_valid, in_ready, fp (and the exception counters when
//   FP_PACKER_EXC_CNT_EN is defined) on every falling edge; directed cases
//   pin the model with hand-computed words.
// -----------------------------------------------------------------------------
module tb_fp_packer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        db;
   logic        s;
   logic [10:0] e;
   logic [52:0] f;
   logic [3:0]  fl;
   logic [52:0] nan;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] fp;
`ifdef FP_PACKER_EXC_CNT_EN
   logic [15:0] nan_cnt;
   logic [15:0] inf_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   fp_packer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .db        (db),
      .s         (s),
      .e         (e),
      .f         (f),
      .fl        (fl),
      .nan       (nan),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fp        (fp)
`ifdef FP_PACKER_EXC_CNT_EN
      ,
      .nan_cnt   (nan_cnt),
      .inf_cnt   (inf_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: decide class by flag priority, form the double-width
   // fields, then narrow to single if needed.
   function automatic logic [63:0] model(input logic dbl, input logic sg,
                                         input logic [10:0] ex_in, input logic [52:0] sig,
                                         input logic [3:0] flg, input logic [52:0] nw);
      logic        sign;
      logic [10:0] ex;
      logic [51:0] fr;
      if (flg[1] | flg[0]) begin
         sign = nw[52]; ex = 11'h7FF; fr = nw[51:0]; fr[51] = 1'b1;
      end else if (flg[2]) begin
         sign = sg; ex = 11'h7FF; fr = 52'h0;
      end else if (flg[3]) begin
         sign = sg; ex = 11'h0; fr = 52'h0;
      end else begin
         sign = sg; ex = (sig[52] == 1'b1) ? ex_in : 11'h0; fr = sig[51:0];
      end
      if (dbl) return {sign, ex, fr};
      else     return {sign, ex[7:0], fr[51:29], 32'h0};
   endfunction

   typedef struct {
      logic [63:0] w;
      int          cls;   // 0 other, 1 inf, 2 nan
      int          age;   // edges since acceptance
   } ent_t;

   ent_t q[$];
   int   m_nan = 0;
   int   m_inf = 0;

   always @(negedge clk) begin
      logic ev, er;
      ent_t n;
      if (!rst_n) begin
         q.delete();
         m_nan = 0;
         m_inf = 0;
      end else begin
         ev = (q.size() > 0) && (q[0].age >= 1);
         er = (q.size() < 2) || out_ready;
         check("out_valid", {63'h0, out_valid}, {63'h0, ev});
         check("in_ready", {63'h0, in_ready}, {63'h0, er});
         if (ev) check("fp", fp, q[0].w);
`ifdef FP_PACKER_EXC_CNT_EN
         check("nan_cnt", {48'h0, nan_cnt}, 64'(m_nan));
         check("inf_cnt", {48'h0, inf_cnt}, 64'(m_inf));
`endif
         if (ev && out_ready) begin
            if (q[0].cls == 2 && m_nan < 65535) m_nan++;
            if (q[0].cls == 1 && m_inf < 65535) m_inf++;
            void'(q.pop_front());
         end
         foreach (q[i]) q[i].age++;
         if (in_valid && er) begin
            n.w   = model(db, s, e, f, fl, nan);
            n.cls = (fl[1] | fl[0]) ? 2 : (fl[2] ? 1 : 0);
            n.age = 0;
            q.push_back(n);
         end
      end
   end

   task automatic rand_item();
      logic [63:0] r;
      db = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      e  = 11'($urandom);
      r  = {$urandom, $urandom};
      f  = r[52:0];
      r  = {$urandom, $urandom};
      nan = r[52:0];
      fl = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic db_i, input logic s_i, input logic [10:0] e_i,
                       input logic [52:0] f_i, input logic [3:0] fl_i, input logic [52:0] nan_i);
      int   n;
      logic acc;
      db = db_i; s = s_i; e = e_i; f = f_i; fl = fl_i; nan = nan_i;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 200);
      in_valid = 1'b0;
      if (!acc) check("send_timeout", 64'h0, 64'h1);
   endtask

   task automatic expect_out(input string name, input logic [63:0] lit, input int lat_exp);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 10);
      check({name, "_latency"}, 64'(n), 64'(lat_exp));
      check(name, fp, lit);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int acc;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      db = 1'b0; s = 1'b0; e = '0; f = '0; fl = '0; nan = '0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", {63'h0, out_valid}, 64'h0);
      check("rst_in_ready", {63'h0, in_ready}, 64'h1);
      check("rst_fp", fp, 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

`ifdef FP_PACKER_EXC_CNT_EN
      // 3 NaN + 1 INF emitted, then 1 NaN held back by out_ready=0.
      send(1, 0, 11'h0, 53'h0, 4'b0001, 53'h0);
      send(0, 0, 11'h0, 53'h0, 4'b0010, 53'h0);
      send(1, 1, 11'h0, 53'h0, 4'b0100, 53'h0);
      send(1, 0, 11'h0, 53'h0, 4'b0011, 53'h0);
      idle(3);
      out_ready = 1'b0;
      send(1, 0, 11'h0, 53'h0, 4'b0001, 53'h0);
      idle(3);
      check("cnt_nan3", {48'h0, nan_cnt}, 64'd3);
      check("cnt_inf1", {48'h0, inf_cnt}, 64'd1);
      out_ready = 1'b1;
      idle(3);
`endif

      // Directed words.
      send(1, 0, 11'h3FF, 53'h1 << 52, 4'b0000, 53'h0);
      expect_out("dbl_one", 64'h3FF0000000000000, 2);
      send(0, 1, 11'h080, 53'h1 << 52, 4'b0000, 53'h0);
      expect_out("sgl_neg_two", 64'hC000000000000000, 2);
      send(0, 0, 11'h005, 53'h1 << 29, 4'b0000, 53'h0);
      expect_out("sgl_denorm", 64'h0000000100000000, 2);
      send(1, 0, 11'h123, 53'h1F_0000_0000_1234, 4'b0101, {1'b1, 52'h0_0000_0000_0001});
      expect_out("nan_over_inf", 64'hFFF8000000000001, 2);
      send(1, 1, 11'h3FF, 53'h1 << 52, 4'b1000, 53'h0);
      expect_out("neg_zero", 64'h8000000000000000, 2);
      send(0, 1, 11'h0FF, 53'h1 << 52, 4'b0010, 53'h0);
      expect_out("sgl_qnan", 64'h7FC0000000000000, 2);
      send(1, 0, 11'h123, 53'h1, 4'b0000, 53'h0);
      expect_out("dbl_denorm", 64'h0000000000000001, 2);
      send(0, 1, 11'h7FF, 53'h0, 4'b0110, 53'h0);
      expect_out("sgl_neg_inf_vs_snan", 64'h7FC0000000000000, 2);

      // Backpressure: offer results for 6 cycles with out_ready low.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         rand_item();
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp_accepted", 64'(acc), 64'd2);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int c = 0; c < 20; c++) begin
         rand_item();
         idle(1);
      end
      in_valid = 1'b0;
      idle(3);

      // Reset mid-flight.
      out_ready = 1'b0;
      rand_item(); fl = 4'h0;
      send(db, s, e, f, fl, nan);
      rand_item();
      send(db, s, e, f, fl, nan);
      idle(1);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
      check("mid_rst_fp", fp, 64'h0);
      check("mid_rst_in_ready", {63'h0, in_ready}, 64'h1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(6);

      // Random traffic with random backpressure.
      for (int c = 0; c < 3000; c++) begin
         rand_item();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         idle(1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle(4);

`ifdef FP_PACKER_EXC_CNT_EN
      // Drive the NaN counter to saturation and beyond.
      db = 1'b1; fl = 4'b0001; nan = '0;
      in_valid = 1'b1;
      idle(65600);
      in_valid = 1'b0;
      idle(4);
      check("nan_cnt_sat", {48'h0, nan_cnt}, 64'hFFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fp_packer.md
# fp_packer

Result packer for the FPU back end. Takes a rounded result as sign, biased exponent, 53-bit significand with explicit hidden bit, and exception flags, and packs it into IEEE-754 double or single format. It is the inverse of the operand unpacker and uses the same flag ordering and the same 53-bit NaN word. It is a two-stage valid/ready pipeline that sits between the rounder and the register-file write port.

## Interface
- No parameters; widths are fixed by the double format.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  upstream result valid.
- `in_ready`  out  1  packer can accept a result this cycle.
- `db`  in  1  1 = double, 0 = single.
- `s`  in  1  result sign.
- `e`  in  11  biased exponent. Single uses `e[7:0]`; `e[10:8]` is ignored.
- `f`  in  53  significand. `f[52]` is the hidden bit; single uses `f[52:29]`.
- `fl`  in  4  flags: `{ZERO, INF, SNAN, NAN}`, same order as the unpacker.
- `nan`  in  53  `{nan_sign, nan_frac[51:0]}` from the NaN selector.
- `out_valid`  out  1  packed word valid.
- `out_ready`  in  1  downstream accepts.
- `fp`  out  64  packed result.
- `nan_cnt`  out  16  present only with the macro (see Configuration).
- `inf_cnt`  out  16  present only with the macro (see Configuration).

## Operation
- Stage 1 (S1) captures the inputs and decodes the class. Class priority: `NAN|SNAN` > `INF` > `ZERO` > finite.
- Stage 2 (S2) registers the packed word onto `fp`.
- Field packing, double: `{sign, exp[10:0], frac[51:0]}`.
- Field packing, single: `fp[63:32] = {sign, exp[7:0], frac[22:0]}`, and `fp[31:0] = 0`.
- NaN class:
  - sign = `nan[52]`.
  - exp = all ones.
  - frac = `nan[51:0]` for double; `nan[51:29]` for single.
  - The quiet bit is forced to 1 in both formats (frac MSB).
  - `s`, `e`, `f` are ignored.
- INF class: sign = `s`, exp = all ones, frac = 0.
- ZERO class: sign = `s`, exp = 0, frac = 0. The sign is preserved, so -0 packs as `0x8000000000000000`.
- Finite class, `f[52]=1`: exp = `e`, frac = `f[51:0]` for double or `f[51:29]` for single.
- Finite class, `f[52]=0` (denormal): the exp field is forced to 0 regardless of `e`; frac as above.
- No rounding or range checking is performed. Overflow and underflow have already been resolved upstream into the flags.

## Timing
- Latency: 2 cycles from an accepted input (`in_valid && in_ready`) to `out_valid`. Throughput is 1 per cycle.
- Stage valids: `v1`, `v2`. S2 advances when `!v2 || out_ready`. S1 advances when S2 advances or `!v1`.
- `in_ready = !v1 || !v2 || out_ready`. This is combinational from `out_ready`; there is no combinational path from `in_valid` to `in_ready`.
- While `out_valid && !out_ready`, `fp` holds stable.
- Simultaneous accept and emit in the same cycle is legal. There are no bubbles while both ends are ready.
- At most 2 results are in flight; order is preserved.
- Reset values: `v1=v2=0`, `out_valid=0`, `in_ready=1`, `fp=0`, counters 0.
- Reset asserted mid-operation: in-flight results are discarded and never emitted.
- Inputs are sampled only when the S1 transfer occurs. Input values on cycles where `in_valid=0` have no effect.

## Configuration
- Macro: `FP_PACKER_EXC_CNT_EN`.
- Defined:
  - `nan_cnt` increments on each output transfer (`out_valid && out_ready`) of a NaN-class word.
  - `inf_cnt` does the same for INF-class words.
  - Both counters are 16-bit and saturate at `0xFFFF`. Class is carried in S2 with 2 extra bits.
- Undefined: the ports and counter logic are absent, and datapath behaviour is identical.

## Test plan
- Double 1.0: `db=1, s=0, e=0x3FF, f=1<<52, fl=0` -> `fp=0x3FF0000000000000`, `out_valid` 2 cycles after accept.
- Single -2.0 and single denormal:
  - `db=0, s=1, e=0x080, f=1<<52` -> `fp=0xC000000000000000`.
  - `db=0, f=1<<29, e=0x05` -> `fp=0x0000000100000000`.
- Flag priority: `fl=4'b0101` (INF+NAN), `nan={1, 52'h0_0000_0000_0001}` -> `fp=0xFFF8000000000001`. `fl=4'b1000, s=1` -> `0x8000000000000000`.
- Backpressure: hold `out_ready=0`, offer 4 back-to-back results -> exactly 2 accepted, `in_ready=0` from the third cycle on, `fp` stable. Release `out_ready` -> the 2 held results emit in order, then streaming resumes at 1/cycle.
- Reset mid-flight: 2 results in flight, pulse `rst_n` low asynchronously -> `out_valid=0`, `fp=0` immediately, nothing emitted after release.
- With `FP_PACKER_EXC_CNT_EN`: 3 NaN and 1 INF transfers, plus 1 NaN stalled with `out_ready=0` -> `nan_cnt=3, inf_cnt=1`. Preload near saturation -> counter holds at `0xFFFF`.
